// File: rtl/if_fetch_unit.sv
// IF-stage fetch engine: owns the PC, requests words from instruction
// memory and feeds PCplus4F/PCplus8F/InstrF to the IF/ID register.
// Ports:
//   clk, reset (async, active-high)
//   stall, Int, eret, epc, branch_taken, branch_target -- control in
//   im_req/im_addr out, im_ready/im_rdata in           -- memory handshake
//   PCplus4F, PCplus8F, InstrF, fetch_exc              -- to IF/ID
// Build option: FETCH_ALIGN_CHECK_EN enables the AdEL address check.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  parameter logic [31:0] ADDR_LO   = 32'h0000_3000,
  parameter logic [31:0] ADDR_HI   = 32'h0000_4FFF
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        Int,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ready,
  input  logic [31:0] im_rdata,
  output logic [31:0] PCplus4F,
  output logic [31:0] PCplus8F,
  output logic [31:0] InstrF,
  output logic        fetch_exc
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_req_addr;
  logic [31:0] r_buf;
  logic [31:0] r_tgt;
  logic        r_tgt_valid;

  state_t      w_state_nx;
  logic [31:0] w_req_addr_nx;
  logic [31:0] w_buf_nx;
  logic [31:0] w_tgt_nx;
  logic        w_tgt_valid_nx;

  logic        w_bad;
  logic        w_rdy;
  logic        w_flush;
  logic [31:0] w_ftgt;
  logic        w_deliver;

`ifdef FETCH_ALIGN_CHECK_EN
  assign w_bad = (r_req_addr[1:0] != 2'b00)
              || (r_req_addr < ADDR_LO)
              || (r_req_addr > ADDR_HI);
  assign im_addr = r_req_addr;
`else
  assign w_bad = 1'b0;
  assign im_addr = {r_req_addr[31:2], 2'b00};
`endif

  assign fetch_exc = w_bad;
  assign im_req = (r_state != S_HOLD) && !w_bad;
  // No request is on the bus while the address is illegal.
  assign w_rdy = im_ready && !w_bad;
  assign w_flush = Int || eret;
  assign w_ftgt = Int ? EXC_ENTRY : epc;
  assign w_deliver = (((r_state == S_FETCH) && w_rdy)
                     || (r_state == S_HOLD))
                     && !stall && !w_flush;

  assign PCplus4F = r_req_addr + 32'd4;
  assign PCplus8F = r_req_addr + 32'd8;

  always_comb begin
    InstrF = 32'h0;
    if ((r_state == S_FETCH) && w_rdy)
      InstrF = im_rdata;
    else if (r_state == S_HOLD)
      InstrF = r_buf;
  end

  always_comb begin
    w_state_nx     = r_state;
    w_req_addr_nx  = r_req_addr;
    w_buf_nx       = r_buf;
    w_tgt_nx       = r_tgt;
    w_tgt_valid_nx = r_tgt_valid;
    unique case (r_state)
      S_FETCH: begin
        if (w_flush) begin
          // An issued request cannot be cancelled: wait it out.
          if (w_rdy || w_bad) begin
            w_req_addr_nx  = w_ftgt;
            w_tgt_valid_nx = 1'b0;
          end else begin
            w_tgt_nx       = w_ftgt;
            w_tgt_valid_nx = 1'b1;
            w_state_nx     = S_DRAIN;
          end
        end else if (w_rdy && stall) begin
          w_buf_nx   = im_rdata;
          w_state_nx = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_flush) begin
          w_req_addr_nx  = w_ftgt;
          w_tgt_valid_nx = 1'b0;
          w_state_nx     = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (w_flush) begin
          w_tgt_nx = w_ftgt;
        end else if (im_ready) begin
          w_req_addr_nx  = r_tgt;
          w_tgt_valid_nx = 1'b0;
          w_state_nx     = S_FETCH;
        end
      end
      default: w_state_nx = S_FETCH;
    endcase
    // Delivered word is the delay slot; a pending branch lands after it.
    if (w_deliver) begin
      w_req_addr_nx  = branch_taken ? branch_target
                     : r_tgt_valid  ? r_tgt
                     : r_req_addr + 32'd4;
      w_tgt_valid_nx = 1'b0;
      w_state_nx     = S_FETCH;
    end else if (branch_taken && !stall && !w_flush
                 && (r_state != S_DRAIN)) begin
      w_tgt_nx       = branch_target;
      w_tgt_valid_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_req_addr  <= RESET_PC;
      r_buf       <= 32'h0;
      r_tgt       <= 32'h0;
      r_tgt_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_req_addr  <= w_req_addr_nx;
      r_buf       <= w_buf_nx;
      r_tgt       <= w_tgt_nx;
      r_tgt_valid <= w_tgt_valid_nx;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit.
// Memory returns 0xA5000000 ^ addr ^ mask.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        Int;
  logic        eret;
  logic [31:0] epc;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ready;
  logic [31:0] im_rdata;
  logic [31:0] PCplus4F;
  logic [31:0] PCplus8F;
  logic [31:0] InstrF;
  logic        fetch_exc;
  logic [31:0] mask;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign im_rdata = 32'hA500_0000 ^ im_addr ^ mask;

  if_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .Int(Int),
    .eret(eret), .epc(epc), .branch_taken(branch_taken),
    .branch_target(branch_target), .im_req(im_req),
    .im_addr(im_addr), .im_ready(im_ready), .im_rdata(im_rdata),
    .PCplus4F(PCplus4F), .PCplus8F(PCplus8F), .InstrF(InstrF),
    .fetch_exc(fetch_exc)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; Int = 1'b0; eret = 1'b0;
    epc = 32'h0; branch_taken = 1'b0; branch_target = 32'h0;
    im_ready = 1'b1; mask = 32'h0;
    @(negedge clk);
    chk("rst_addr", im_addr, 32'h3000);
    chk("rst_pc4", PCplus4F, 32'h3004);
    chk("rst_pc8", PCplus8F, 32'h3008);
    chk("rst_req", {31'd0, im_req}, 32'd1);
    chk("rst_exc", {31'd0, fetch_exc}, 32'd0);
    nxt();
    reset = 1'b0;
    // T1 zero-wait stream
    @(negedge clk);
    chk("t1_a0", im_addr, 32'h3000);
    chk("t1_i0", InstrF, 32'hA500_3000);
    nxt();
    @(negedge clk);
    chk("t1_a1", im_addr, 32'h3004);
    chk("t1_pc4", PCplus4F, 32'h3008);
    chk("t1_i1", InstrF, 32'hA500_3004);
    nxt();
    @(negedge clk);
    chk("t1_a2", im_addr, 32'h3008);
    chk("t1_i2", InstrF, 32'hA500_3008);
    nxt();
    // T2 two wait cycles at 0x300C
    im_ready = 1'b0;
    @(negedge clk);
    chk("t2_w0_i", InstrF, 32'h0);
    chk("t2_w0_a", im_addr, 32'h300C);
    nxt();
    @(negedge clk);
    chk("t2_w1_i", InstrF, 32'h0);
    chk("t2_w1_a", im_addr, 32'h300C);
    chk("t2_w1_r", {31'd0, im_req}, 32'd1);
    nxt();
    im_ready = 1'b1;
    @(negedge clk);
    chk("t2_dl", InstrF, 32'hA500_300C);
    nxt();
    // T3 stall for 3 cycles at 0x3010
    stall = 1'b1;
    @(negedge clk);
    chk("t3_s0", InstrF, 32'hA500_3010);
    nxt();
    mask = 32'hFFFF_0000;
    @(negedge clk);
    chk("t3_h1_r", {31'd0, im_req}, 32'd0);
    chk("t3_h1_i", InstrF, 32'hA500_3010);
    nxt();
    @(negedge clk);
    chk("t3_h2_i", InstrF, 32'hA500_3010);
    chk("t3_h2_a", im_addr, 32'h3010);
    nxt();
    stall = 1'b0;
    @(negedge clk);
    chk("t3_rel", InstrF, 32'hA500_3010);
    nxt();
    mask = 32'h0;
    @(negedge clk);
    chk("t3_adv", im_addr, 32'h3014);
    nxt();
    // T4 branch while delay slot 0x3018 waits
    im_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h3100;
    @(negedge clk);
    chk("t4_wait", InstrF, 32'h0);
    nxt();
    im_ready = 1'b1; branch_taken = 1'b0;
    @(negedge clk);
    chk("t4_ds_a", im_addr, 32'h3018);
    chk("t4_ds_i", InstrF, 32'hA500_3018);
    nxt();
    @(negedge clk);
    chk("t4_tgt", im_addr, 32'h3100);
    nxt();
    branch_taken = 1'b1; branch_target = 32'h3200;
    @(negedge clk);
    chk("t4b_a", im_addr, 32'h3104);
    nxt();
    branch_taken = 1'b0;
    @(negedge clk);
    chk("t4b_tgt", im_addr, 32'h3200);
    // T5 Int during outstanding request
    im_ready = 1'b0; Int = 1'b1;
    @(negedge clk);
    chk("t5_i0", InstrF, 32'h0);
    nxt();
    Int = 1'b0;
    @(negedge clk);
    chk("t5_dr_a", im_addr, 32'h3200);
    chk("t5_dr_r", {31'd0, im_req}, 32'd1);
    chk("t5_dr_i", InstrF, 32'h0);
    nxt();
    im_ready = 1'b1;
    @(negedge clk);
    chk("t5_disc", InstrF, 32'h0);
    nxt();
    @(negedge clk);
    chk("t5_vec_a", im_addr, 32'h4180);
    chk("t5_vec_i", InstrF, 32'hA500_4180);
    nxt();
    // eret while holding a stalled word
    stall = 1'b1;
    @(negedge clk);
    chk("er_s", InstrF, 32'hA500_4184);
    nxt();
    eret = 1'b1; epc = 32'h3040;
    @(negedge clk);
    chk("er_h_i", InstrF, 32'hA500_4184);
    chk("er_h_r", {31'd0, im_req}, 32'd0);
    nxt();
    eret = 1'b0; stall = 1'b0;
    @(negedge clk);
    chk("er_a", im_addr, 32'h3040);
    chk("er_i", InstrF, 32'hA500_3040);
    nxt();
    // Int wins over eret
    Int = 1'b1; eret = 1'b1; epc = 32'h3000;
    @(negedge clk);
    nxt();
    Int = 1'b0; eret = 1'b0;
    @(negedge clk);
    chk("prio_a", im_addr, 32'h4180);
    nxt();
    // branch ignored while stalled
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h3300;
    @(negedge clk);
    nxt();
    stall = 1'b0; branch_taken = 1'b0;
    @(negedge clk);
    chk("stbr_i", InstrF, 32'hA500_4184);
    nxt();
    @(negedge clk);
    chk("stbr_a", im_addr, 32'h4188);
`ifndef FETCH_ALIGN_CHECK_EN
    // wrap-around and low-bit masking
    eret = 1'b1; epc = 32'hFFFF_FFFC;
    nxt();
    eret = 1'b0;
    @(negedge clk);
    chk("wr_a", im_addr, 32'hFFFF_FFFC);
    chk("wr_pc4", PCplus4F, 32'h0);
    chk("wr_pc8", PCplus8F, 32'h4);
    nxt();
    eret = 1'b1; epc = 32'h3042;
    @(negedge clk);
    chk("wr_0", im_addr, 32'h0);
    nxt();
    eret = 1'b0;
    @(negedge clk);
    chk("mis_a", im_addr, 32'h3040);
    chk("mis_x", {31'd0, fetch_exc}, 32'd0);
    nxt();
`else
    // T6 illegal epc raises AdEL until Int
    eret = 1'b1; epc = 32'h3002;
    nxt();
    eret = 1'b0;
    @(negedge clk);
    chk("t6_exc", {31'd0, fetch_exc}, 32'd1);
    chk("t6_req", {31'd0, im_req}, 32'd0);
    chk("t6_i", InstrF, 32'h0);
    nxt();
    @(negedge clk);
    chk("t6_hold", {31'd0, fetch_exc}, 32'd1);
    Int = 1'b1;
    nxt();
    Int = 1'b0;
    @(negedge clk);
    chk("t6_vec", im_addr, 32'h4180);
    chk("t6_clr", {31'd0, fetch_exc}, 32'd0);
    nxt();
`endif
    // reset during an outstanding request
    im_ready = 1'b0;
    nxt();
    reset = 1'b1;
    #1;
    chk("rr_a", im_addr, 32'h3000);
    nxt();
    reset = 1'b0; im_ready = 1'b1;
    @(negedge clk);
    chk("rr_i", InstrF, 32'hA500_3000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
